bias_relu_1: RTL and testbench

BIAS_RELU_1 -- requirements
Module: bias_relu_1

---
 rtl/bias_relu_1_pkg.sv | 16 +
 rtl/bias_regfile.sv | 27 ++
 rtl/bias_relu_1.sv | 153 +++++++++++++++
 tb/tb_bias_relu_1.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_relu_1_pkg.sv
// Shared sizes and types for the bias + ReLU stage.
// These values stand in for the shared layer headers so that every file
// of the stage picks them up from one place.
package bias_relu_1_pkg;

  // Output channels per pixel (kern_s_k_1) and coefficient width (coeff_width).
  localparam int KERN_S_K_1  = 4;
  localparam int COEFF_WIDTH = 16;

  // LOAD: pull one frame of biases. RUN: stream pixels through bias + ReLU.
  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/bias_regfile.sv
// Per-channel bias storage: one synchronous write port, one asynchronous read.
// Contents are deliberately not reset; every frame reloads them before use.
module bias_regfile #(
  parameter int NUM_CH  = 4,
  parameter int COEFF_W = 16,
  parameter int AW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [COEFF_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [COEFF_W-1:0] o_rdata
);

  logic [COEFF_W-1:0] r_mem [NUM_CH];

  // Write one bias per popped FIFO word.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bias_relu_1.sv
// Bias add + ReLU + saturation stage between FIFO-style streams.
// A frame is NUM_CH biases followed by NUM_PIX*NUM_CH accumulators in
// channel-fastest order; each accumulator gets its channel's bias added,
// is clamped to [0, 2^(COEFF_W-1)-1] and is registered to the output.
//
// Handshake: a FIFO word moves on any rising edge where the block drives
// *_read (or *_write) high; *_read is only raised when the matching
// *_empty_n is high, *_write only when output_V_full_n is high, and data
// presented with an un-taken word (out_valid && !full_n) stays stable.
module bias_relu_1
  import bias_relu_1_pkg::*;
#(
  parameter int  NUM_CH  = KERN_S_K_1,
  parameter int  NUM_PIX = 64,
  parameter int  ACC_W   = 32,
  parameter int  COEFF_W = COEFF_WIDTH,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PIX_W   = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [COEFF_W-1:0] bias_V_dout,
  input  logic               bias_V_empty_n,
  output logic               bias_V_read,
  input  logic [ACC_W-1:0]   input_V_dout,
  input  logic               input_V_empty_n,
  output logic               input_V_read,
  output logic [COEFF_W-1:0] output_V_din,
  input  logic               output_V_full_n,
  output logic               output_V_write,
  output state_e             dbg_state,
  output logic [CH_W-1:0]    dbg_ch
);

  // Largest positive output, zero-extended to the sum width for comparison.
  localparam logic [COEFF_W-1:0] OUT_MAX     = {1'b0, {(COEFF_W-1){1'b1}}};
  localparam logic [ACC_W:0]     SUM_SAT_MAX = {{(ACC_W+1-COEFF_W){1'b0}}, OUT_MAX};

  state_e             r_state;
  state_e             w_next_state;
  logic [CH_W-1:0]    r_ch;
  logic [PIX_W-1:0]   r_pix;
  logic               r_out_valid;
  logic [COEFF_W-1:0] r_out_data;

  logic               w_bias_pop;
  logic               w_in_acc;
  logic               w_out_write;
  logic               w_last_ch;
  logic               w_last_pix;
  logic [COEFF_W-1:0] w_bias;
  logic [ACC_W:0]     w_sum;
  logic [COEFF_W-1:0] w_result;

  assign w_last_ch  = (r_ch == CH_W'(NUM_CH - 1));
  assign w_last_pix = (r_pix == PIX_W'(NUM_PIX - 1));

  // Reset also gates the bias pop so nothing is consumed while held in reset.
  assign w_bias_pop  = !ap_rst && (r_state == ST_LOAD) && bias_V_empty_n;
  // A new input is taken only when the output register is free or draining.
  assign w_in_acc    = (r_state == ST_RUN) && input_V_empty_n &&
                       (!r_out_valid || output_V_full_n);
  assign w_out_write = r_out_valid && output_V_full_n;

  assign bias_V_read    = w_bias_pop;
  assign input_V_read   = w_in_acc;
  assign output_V_write = w_out_write;
  assign output_V_din   = r_out_data;
  assign dbg_state      = r_state;
  assign dbg_ch         = r_ch;

  bias_regfile #(
    .NUM_CH  (NUM_CH),
    .COEFF_W (COEFF_W),
    .AW      (CH_W)
  ) u_bias_regfile (
    .i_clk   (ap_clk),
    .i_we    (w_bias_pop),
    .i_waddr (r_ch),
    .i_wdata (bias_V_dout),
    .i_raddr (r_ch),
    .o_rdata (w_bias)
  );

  // Sign-extend both operands one bit past ACC_W so the add cannot overflow.
  assign w_sum = {input_V_dout[ACC_W-1], input_V_dout} +
                 {{(ACC_W+1-COEFF_W){w_bias[COEFF_W-1]}}, w_bias};

  // Rectify negative sums to zero, saturate large positive sums.
  always_comb begin
    w_result = w_sum[COEFF_W-1:0];
    if (w_sum[ACC_W]) begin
      w_result = '0;
    end else if (w_sum > SUM_SAT_MAX) begin
      w_result = OUT_MAX;
    end
  end

  // State register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: leave LOAD on the last bias, leave RUN on the last sample of the frame.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_LOAD: if (w_bias_pop && w_last_ch)              w_next_state = ST_RUN;
      ST_RUN:  if (w_in_acc && w_last_ch && w_last_pix)  w_next_state = ST_LOAD;
      default:                                           w_next_state = ST_LOAD;
    endcase
  end

  // Channel / pixel counters shared by the bias load and the pixel stream.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_ch  <= '0;
      r_pix <= '0;
    end else if (w_bias_pop) begin
      if (w_last_ch) begin
        r_ch  <= '0;
        r_pix <= '0;
      end else begin
        r_ch <= r_ch + 1'b1;
      end
    end else if (w_in_acc) begin
      if (w_last_ch) begin
        r_ch  <= '0;
        r_pix <= w_last_pix ? '0 : r_pix + 1'b1;
      end else begin
        r_ch <= r_ch + 1'b1;
      end
    end
  end

  // Output register: load on acceptance, release on a write with no refill.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_in_acc) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
    end else if (w_out_write) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bias_relu_1.sv
// Self-checking bench for bias_relu_1: FIFO models around the DUT, a
// table of arithmetic vectors, hand sequences for the multi-cycle corners
// and randomized frames checked against an arithmetic reference.
module tb_bias_relu_1;
  import bias_relu_1_pkg::*;

  localparam int  NCH   = 4;
  localparam int  NPIX  = 2;
  localparam int  AW    = 32;
  localparam int  CW    = 16;
  localparam int  FRAME = NCH * NPIX;
  localparam longint OUT_MAXV = (longint'(1) << (CW - 1)) - 1;

  typedef struct {
    logic signed [AW-1:0] acc;
    logic signed [CW-1:0] bias;
    logic [CW-1:0]        exp;
  } vec_t;

  typedef logic signed [CW-1:0] bias_arr_t [NCH];
  typedef logic signed [AW-1:0] in_arr_t   [FRAME];
  typedef logic [CW-1:0]        exp_arr_t  [FRAME];

  // ---------------- clock / reset / DUT ----------------
  logic          ap_clk;
  logic          ap_rst;
  logic [CW-1:0] bias_V_dout;
  logic          bias_V_empty_n;
  logic          bias_V_read;
  logic [AW-1:0] input_V_dout;
  logic          input_V_empty_n;
  logic          input_V_read;
  logic [CW-1:0] output_V_din;
  logic          output_V_full_n;
  logic          output_V_write;
  state_e        dbg_state;
  logic [1:0]    dbg_ch;

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  bias_relu_1 #(.NUM_CH(NCH), .NUM_PIX(NPIX), .ACC_W(AW), .COEFF_W(CW)) dut (
    .ap_clk          (ap_clk),
    .ap_rst          (ap_rst),
    .bias_V_dout     (bias_V_dout),
    .bias_V_empty_n  (bias_V_empty_n),
    .bias_V_read     (bias_V_read),
    .input_V_dout    (input_V_dout),
    .input_V_empty_n (input_V_empty_n),
    .input_V_read    (input_V_read),
    .output_V_din    (output_V_din),
    .output_V_full_n (output_V_full_n),
    .output_V_write  (output_V_write),
    .dbg_state       (dbg_state),
    .dbg_ch          (dbg_ch)
  );

  // ---------------- bench state ----------------
  logic signed [CW-1:0] bias_src [$];
  logic signed [AW-1:0] in_src [$];
  logic [CW-1:0]        exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  bit bias_gap, in_gap, bp, rnd;
  int pending, acc_total, frame_acc;
  bit lat_chk, stall_prev, reload_chk;
  logic [CW-1:0] stall_val;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: bias add, then clamp to [0, 2^(CW-1)-1].
  function automatic logic [CW-1:0] ref_out(input logic signed [AW-1:0] x,
                                            input logic signed [CW-1:0] b);
    longint s;
    s = longint'(x) + longint'(b);
    if (s < 0)        return '0;
    if (s > OUT_MAXV) return CW'(OUT_MAXV);
    return CW'(s);
  endfunction

  task automatic drive();
    bias_V_empty_n  = (bias_src.size() > 0) && !bias_gap;
    bias_V_dout     = (bias_src.size() > 0) ? bias_src[0] : '0;
    input_V_empty_n = (in_src.size() > 0) && !in_gap;
    input_V_dout    = (in_src.size() > 0) ? in_src[0] : '0;
    output_V_full_n = !bp;
  endtask

  task automatic push_model_frame(input bias_arr_t b, input in_arr_t x);
    for (int c = 0; c < NCH; c++) bias_src.push_back(b[c]);
    for (int k = 0; k < FRAME; k++) begin
      in_src.push_back(x[k]);
      exp_q.push_back(ref_out(x[k], b[k % NCH]));
    end
  endtask

  task automatic push_exp_frame(input bias_arr_t b, input in_arr_t x, input exp_arr_t e);
    for (int c = 0; c < NCH; c++) bias_src.push_back(b[c]);
    for (int k = 0; k < FRAME; k++) begin
      in_src.push_back(x[k]);
      exp_q.push_back(e[k]);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then update FIFO models after the edge.
  task automatic cyc();
    logic rb, ri, wo;
    logic [CW-1:0] od;
    @(negedge ap_clk);
    rb = bias_V_read; ri = input_V_read; wo = output_V_write; od = output_V_din;
    if (reload_chk) begin
      check(dbg_state == ST_LOAD, "frame_reload_state", longint'(dbg_state), longint'(ST_LOAD));
      check(rb == bias_V_empty_n, "frame_reload_read", rb, bias_V_empty_n);
      reload_chk = 1'b0;
    end
    if (!output_V_full_n && pending > 0) begin
      check(ri == 1'b0, "bp_no_read", ri, 0);
      if (stall_prev) check(od == stall_val, "bp_stable", od, stall_val);
      stall_prev = 1'b1;
      stall_val  = od;
    end else begin
      stall_prev = 1'b0;
    end
    if (lat_chk && output_V_full_n) check(wo == 1'b1, "latency_write", wo, 1);
    lat_chk = ri;
    if (rb) check(bias_src.size() > 0, "bias_read_when_empty", bias_src.size(), 1);
    if (ri) check(in_src.size() > 0, "input_read_when_empty", in_src.size(), 1);
    if (wo) begin
      check(exp_q.size() > 0, "extra_output", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        check(od == exp_q[0], "output_data", od, exp_q[0]);
        void'(exp_q.pop_front());
      end
      pending--;
    end
    @(posedge ap_clk);
    #1;
    if (rb && bias_src.size() > 0) void'(bias_src.pop_front());
    if (ri && in_src.size() > 0) begin
      void'(in_src.pop_front());
      pending++;
      acc_total++;
      frame_acc++;
      if (frame_acc == FRAME) begin
        frame_acc  = 0;
        reload_chk = 1'b1;
      end
    end
    if (rnd) begin
      bias_gap = ($urandom_range(0, 3) == 0);
      in_gap   = ($urandom_range(0, 3) == 0);
      bp       = ($urandom_range(0, 3) == 0);
    end
    drive();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((bias_src.size() > 0 || in_src.size() > 0 || exp_q.size() > 0) && n < budget) begin
      cyc();
      n++;
    end
    check(n < budget, "drain_timeout", n, budget);
  endtask

  task automatic run_until_accepts(input int cnt, input int budget);
    int n = 0;
    int start = acc_total;
    while (acc_total - start < cnt && n < budget) begin
      cyc();
      n++;
    end
    check(n < budget, "accept_timeout", acc_total - start, cnt);
  endtask

  // ---------------- test sequence ----------------
  vec_t      tbl [12];
  bias_arr_t b;
  in_arr_t   x;
  exp_arr_t  e;

  initial begin
    tbl[0]  = '{32'sd1,          16'sd10,    16'd11};
    tbl[1]  = '{32'sd1,          -16'sd5,    16'd0};
    tbl[2]  = '{-32'sd1,         16'sd0,     16'd0};
    tbl[3]  = '{32'sd32767,      16'sd100,   16'd32767};
    tbl[4]  = '{32'sd40000,      16'sd0,     16'd32767};
    tbl[5]  = '{-32'sd70000,     16'sd100,   16'd0};
    tbl[6]  = '{32'sd32667,      16'sd100,   16'd32767};
    tbl[7]  = '{-32'sd100,       16'sd100,   16'd0};
    tbl[8]  = '{32'sd12345,      -16'sd345,  16'd12000};
    tbl[9]  = '{32'sd32766,      16'sd0,     16'd32766};
    tbl[10] = '{32'sh8000_0000,  16'sh8000,  16'd0};
    tbl[11] = '{32'sh7fff_ffff,  16'sh7fff,  16'd32767};

    bias_gap = 0; in_gap = 0; bp = 0; rnd = 0;
    pending = 0; acc_total = 0; frame_acc = 0;
    lat_chk = 0; stall_prev = 0; reload_chk = 0; stall_val = '0;

    // Reset state, with a bias already offered to prove reads stay low.
    ap_rst = 1'b1;
    bias_src.push_back(16'sd7);
    drive();
    #12;
    check(output_V_din == '0, "reset_dout", output_V_din, 0);
    check(output_V_write == 1'b0, "reset_write", output_V_write, 0);
    check(bias_V_read == 1'b0, "reset_bias_read", bias_V_read, 0);
    check(input_V_read == 1'b0, "reset_input_read", input_V_read, 0);
    check(dbg_state == ST_LOAD, "reset_state", longint'(dbg_state), longint'(ST_LOAD));
    check(dbg_ch == 2'd0, "reset_ch", dbg_ch, 0);
    bias_src.delete();
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    drive();

    // Arithmetic table: every channel gets the row's bias, every input the row's value.
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < NCH; c++) bias_src.push_back(tbl[i].bias);
      for (int k = 0; k < FRAME; k++) begin
        in_src.push_back(tbl[i].acc);
        exp_q.push_back(tbl[i].exp);
      end
      drive();
      run_until_idle(200);
    end

    // Two frames back to back: per-channel biases, then reloaded {1,2,3,4}.
    b = '{16'sd10, -16'sd5, 16'sd0, 16'sd100};
    x = '{32'sd1, 32'sd1, -32'sd1, 32'sd32767, 32'sd5, 32'sd6, 32'sd7, 32'sd8};
    e = '{16'd11, 16'd0, 16'd0, 16'd32767, 16'd15, 16'd1, 16'd7, 16'd108};
    push_exp_frame(b, x, e);
    b = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
    x = '{32'sd0, 32'sd0, 32'sd0, 32'sd0, -32'sd2, 32'sd10, -32'sd3, 32'sd100};
    e = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd12, 16'd0, 16'd104};
    push_exp_frame(b, x, e);
    drive();
    run_until_idle(200);

    // Backpressure for 5 cycles mid-stream.
    b = '{16'sd3, -16'sd3, 16'sd500, 16'sd0};
    x = '{32'sd100, 32'sd200, 32'sd300, 32'sd400, 32'sd500, 32'sd600, 32'sd700, 32'sd800};
    push_model_frame(b, x);
    drive();
    run_until_accepts(3, 50);
    bp = 1'b1;
    drive();
    for (int i = 0; i < 5; i++) cyc();
    bp = 1'b0;
    drive();
    run_until_idle(200);

    // Starved bias FIFO during LOAD: counter holds, state stays LOAD.
    b = '{16'sd20, 16'sd30, 16'sd40, 16'sd50};
    x = '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5, 32'sd6, 32'sd7, 32'sd8};
    push_model_frame(b, x);
    drive();
    cyc();
    cyc();
    check(dbg_ch == 2'd2, "starve_ch_before", dbg_ch, 2);
    bias_gap = 1'b1;
    drive();
    for (int i = 0; i < 3; i++) begin
      cyc();
      check(dbg_ch == 2'd2, "starve_ch_hold", dbg_ch, 2);
      check(dbg_state == ST_LOAD, "starve_state", longint'(dbg_state), longint'(ST_LOAD));
    end
    bias_gap = 1'b0;
    drive();
    run_until_idle(200);

    // Mid-frame reset after 3 acceptances, then a fresh frame.
    b = '{16'sd100, 16'sd200, 16'sd300, 16'sd400};
    x = '{32'sd1000, 32'sd1000, 32'sd1000, 32'sd1000, 32'sd1, 32'sd2, 32'sd3, 32'sd4};
    push_model_frame(b, x);
    drive();
    run_until_accepts(3, 50);
    #1;
    ap_rst = 1'b1;
    #1;
    check(output_V_din == '0, "midreset_dout", output_V_din, 0);
    check(output_V_write == 1'b0, "midreset_write", output_V_write, 0);
    check(dbg_state == ST_LOAD, "midreset_state", longint'(dbg_state), longint'(ST_LOAD));
    check(dbg_ch == 2'd0, "midreset_ch", dbg_ch, 0);
    bias_src.delete(); in_src.delete(); exp_q.delete();
    pending = 0; frame_acc = 0; lat_chk = 0; stall_prev = 0; reload_chk = 0;
    b = '{-16'sd10, 16'sd20, -16'sd30, 16'sd40};
    x = '{32'sd50, 32'sd50, 32'sd50, 32'sd50, 32'sd5, 32'sd5, 32'sd5, 32'sd5};
    push_model_frame(b, x);
    drive();
    #1;
    check(bias_V_read == 1'b0, "midreset_bias_read", bias_V_read, 0);
    check(input_V_read == 1'b0, "midreset_input_read", input_V_read, 0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    drive();
    run_until_idle(200);

    // Randomized frames with random gaps and backpressure.
    rnd = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int c = 0; c < NCH; c++) b[c] = CW'($urandom_range(0, 65535));
      for (int k = 0; k < FRAME; k++) begin
        if ($urandom_range(0, 1) == 1) x[k] = AW'(int'($urandom_range(0, 100000)) - 50000);
        else                           x[k] = AW'($urandom);
      end
      push_model_frame(b, x);
    end
    drive();
    run_until_idle(3000);
    rnd = 1'b0; bias_gap = 1'b0; in_gap = 1'b0; bp = 1'b0;
    drive();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
